cpu_exec_ctrl: RTL and testbench
================================

Name: cpu_exec_ctrl

Overview:
- Execution controller for the CPU core. Replaces the free-running divided clock with a single-cycle clock-enable, cpu_en, on the full-rate board clock.
- Modes: HALT, RUN (one enable every RUN_PERIOD cycles), single STEP from a debounced push-button, and BREAK on a PC match.
- Sits between the board switches/buttons and the computer core; its state drives the LEDs and display so the operator can see what the core is doing.

Parameters:
- RUN_PERIOD, 8192: clock cycles between cpu_en pulses in RUN; must be ≥ 3.
- DEB_CYCLES, 65536: consecutive stable samples required to accept a new step_btn level; must be ≥ 2.
- PC_W, 8: width of pc_value and bkpt_pc.

Ports:
- clk  in  1  board clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- run_sw  in  1  raw switch; 1 = run request.
- step_btn  in  1  raw push-button; 1 = pressed.
- clr_count  in  1  synchronous clear of instr_count.
- bkpt_en  in  1  breakpoint enable (quasi-static).
- bkpt_pc  in  PC_W  breakpoint address (quasi-static).
- pc_value  in  PC_W  current core PC.
- cpu_en  out  1  one-cycle enable; the core advances one instruction per high cycle.
- state  out  2  0 = HALT, 1 = RUN, 2 = STEP, 3 = BREAK.
- halted  out  1  1 whenever state != RUN.
- instr_count  out  16  count of issued cpu_en pulses, saturating.

Behaviour:

Reset:
- rst_n low asynchronously forces state = HALT, cpu_en = 0, halted = 1, instr_count = 0.
- Also clears the prescaler, the synchronizer flops and the debouncer (debounced level = 0, counter = 0).
- Reset asserted mid-RUN or mid-STEP drops cpu_en immediately, without waiting for a clock edge.

Input conditioning:
- run_sw and step_btn each pass through 2-flop synchronizers, giving run_s and btn_s.
- Debounce: a counter counts cycles where btn_s ≠ btn_db. When it reaches DEB_CYCLES-1, btn_db takes btn_s and the counter clears. Any cycle with btn_s = btn_db clears the counter.
- step_req is a one-cycle pulse on each 0→1 transition of btn_db.

Outputs:
- cpu_en and halted decode from registered state only; there is no combinational path from any input.
- cpu_en = (state == STEP) OR (state == RUN AND presc == RUN_PERIOD-1).

FSM (one transition per clock):
- HALT: presc held at 0.
  - run_s = 1 → RUN; run takes priority over a simultaneous step_req.
  - else step_req → STEP.
- STEP: lasts exactly one cycle, with cpu_en = 1, then → HALT unconditionally. Consecutive steps need separate debounced presses.
- RUN: presc counts 0 … RUN_PERIOD-1, then wraps to 0.
  - run_s = 0 → HALT and presc clears. If presc was RUN_PERIOD-1 in that cycle, the pulse still issues.
  - Breakpoint check only when presc == 0: if bkpt_en = 1 AND pc_value == bkpt_pc → BREAK; no pulse is issued for that period.
  - Entering RUN from HALT starts with presc = 0, so the check happens on the first RUN cycle.
- BREAK: cpu_en = 0. run_s = 0 → HALT; otherwise stay.
  - To continue past a breakpoint: RUN off, step once, RUN on.
- step_req arriving in RUN, STEP or BREAK is discarded.

instr_count:
- Increments on every cycle with cpu_en = 1 and saturates at 0xFFFF.
- clr_count = 1 sets it to 0 and wins over a same-cycle increment.

Latency:
- run_sw edge to state change: 3 clk.
- Stable button press to cpu_en: 2 + DEB_CYCLES + 1 clk.

Test Plan:
Bench settings for all scenarios: RUN_PERIOD = 8, DEB_CYCLES = 4.
1. Reset, then run_sw = 1 held for 40 cycles → state = 1 from cycle 3; cpu_en pulses at cycles 10, 18, 26, 34, each exactly 1 cycle wide; instr_count = 4; halted = 0.
2. run_sw = 0, step_btn = 1 held for 20 cycles with 1-cycle bounces in the first 3 → exactly one cpu_en pulse; state sequence 0→2→0; instr_count +1. Release and press again → a second single pulse.
3. bkpt_en = 1, bkpt_pc = 0x05, the bench increments pc_value on each cpu_en from 0x00; run_sw = 1 → pulses until pc_value = 0x05, then state = 3 with no further pulses. Then run off, one step, run on → pc_value passes 0x06 and RUN continues.
4. Drop run_sw so run_s falls on the cycle where presc = 7 → that pulse issues and state = 0 the next cycle. Drop it on presc = 3 → no pulse, state = 0.
5. Pulse rst_n low for half a cycle while cpu_en = 1 in RUN → cpu_en = 0 immediately; state = 0, instr_count = 0; the first step after release is accepted normally.
6. Force instr_count to 0xFFFE and issue 3 pulses → count holds at 0xFFFF. Assert clr_count on the same cycle as a cpu_en → count = 0.

Source files
------------

// File: rtl/cpu_exec_ctrl_if.sv
// Board-side control and status bundle for the CPU execution controller.
// The master drives the switches, buttons and core PC; the slave (the
// controller) returns the clock-enable and the status shown on LEDs/display.
interface cpu_exec_ctrl_if #(
  parameter int PC_W = 8
);
  logic            run_sw;
  logic            step_btn;
  logic            clr_count;
  logic            bkpt_en;
  logic [PC_W-1:0] bkpt_pc;
  logic [PC_W-1:0] pc_value;
  logic            cpu_en;
  logic [1:0]      state;
  logic            halted;
  logic [15:0]     instr_count;

  modport master (
    output run_sw, step_btn, clr_count, bkpt_en, bkpt_pc, pc_value,
    input  cpu_en, state, halted, instr_count
  );

  modport slave (
    input  run_sw, step_btn, clr_count, bkpt_en, bkpt_pc, pc_value,
    output cpu_en, state, halted, instr_count
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// Execution controller: turns the run switch, the step button and a PC
// breakpoint into a single-cycle clock-enable for the CPU core, and counts
// how many instructions have been issued.
module cpu_exec_ctrl #(
  parameter int RUN_PERIOD = 8192,
  parameter int DEB_CYCLES = 65536,
  parameter int PC_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_exec_ctrl_if.slave  bus
);

  localparam int PRESC_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(RUN_PERIOD - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t             state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         run_sync_q;
  logic [1:0]         btn_sync_q;
  logic               btn_db_q;
  logic               btn_db_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [15:0]        instr_cnt_q;
  logic [15:0]        instr_cnt_d;

  logic run_s;
  logic btn_s;
  logic step_req;
  logic cpu_en;
  logic bkpt_hit;

  assign run_s    = run_sync_q[1];
  assign btn_s    = btn_sync_q[1];
  assign step_req = btn_db_q & ~btn_db_prev_q;
  assign bkpt_hit = bus.bkpt_en && (bus.pc_value == bus.bkpt_pc);

  // Enable and status are decoded from registered state only, so the async
  // reset removes cpu_en immediately and no input reaches the outputs.
  assign cpu_en          = (state_q == ST_STEP) ||
                           ((state_q == ST_RUN) && (presc_q == PRESC_LAST));
  assign bus.cpu_en      = cpu_en;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q != ST_RUN);
  assign bus.instr_count = instr_cnt_q;

  // Two-flop synchronizers for the raw switch and button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync_q <= 2'b00;
      btn_sync_q <= 2'b00;
    end else begin
      // NOTE: every flop here uses non-blocking assignment so all registers
      // sample the pre-edge values; blocking would collapse the 2-flop chain.
      run_sync_q <= {run_sync_q[0], bus.run_sw};
      btn_sync_q <= {btn_sync_q[0], bus.step_btn};
    end
  end

  // Debouncer: accept a new button level after DEB_CYCLES differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      btn_db_prev_q <= btn_db_q;
      if (btn_s == btn_db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        btn_db_q  <= btn_s;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // Mode FSM with the RUN prescaler; one transition per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      presc_q <= '0;
    end else begin
      case (state_q)
        ST_HALT: begin
          presc_q <= '0;
          if (run_s)         state_q <= ST_RUN;
          else if (step_req) state_q <= ST_STEP;
        end
        ST_STEP: begin
          presc_q <= '0;
          state_q <= ST_HALT;
        end
        ST_RUN: begin
          if (!run_s) begin
            state_q <= ST_HALT;
            presc_q <= '0;
          end else if ((presc_q == '0) && bkpt_hit) begin
            state_q <= ST_BREAK;
            presc_q <= '0;
          end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
          end
        end
        ST_BREAK: begin
          presc_q <= '0;
          if (!run_s) state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_HALT;
          presc_q <= '0;
        end
      endcase
    end
  end

  // Next instruction count: clear wins, otherwise saturating increment.
  always_comb begin
    // NOTE: the default assignment up front keeps this block free of latches.
    instr_cnt_d = instr_cnt_q;
    if (bus.clr_count)                          instr_cnt_d = 16'd0;
    else if (cpu_en && (instr_cnt_q != 16'hFFFF)) instr_cnt_d = instr_cnt_q + 16'd1;
  end

  // Instruction counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_cnt_q <= 16'd0;
    else        instr_cnt_q <= instr_cnt_d;
  end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Directed bench for cpu_exec_ctrl with RUN_PERIOD = 8 and DEB_CYCLES = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cpu_exec_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   track_pc;

  cpu_exec_ctrl_if #(.PC_W(8)) bus ();

  cpu_exec_ctrl #(
    .RUN_PERIOD (8),
    .DEB_CYCLES (4),
    .PC_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n falling edges; the modelled core bumps its PC on each enable.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (track_pc && bus.cpu_en) bus.pc_value = bus.pc_value + 8'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.run_sw    = 1'b0;
    bus.step_btn  = 1'b0;
    bus.clr_count = 1'b0;
    bus.bkpt_en   = 1'b0;
    bus.bkpt_pc   = 8'h00;
    bus.pc_value  = 8'h00;
    track_pc      = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // Hold the button 20 cycles (optionally bouncing), then release 10 cycles.
  task automatic press_btn(input bit bounce, output int pulses, output int at,
                           output logic [1:0] st_at, output logic [1:0] st_next);
    bit want_next;
    pulses    = 0;
    at        = -1;
    st_at     = 2'bxx;
    st_next   = 2'bxx;
    want_next = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20) bus.step_btn = (bounce && (i == 1 || i == 3)) ? 1'b0 : 1'b1;
      else        bus.step_btn = 1'b0;
      tick(1);
      if (want_next) begin
        st_next   = bus.state;
        want_next = 1'b0;
      end
      if (bus.cpu_en) begin
        pulses++;
        at        = i;
        st_at     = bus.state;
        want_next = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.run_sw    = 1'b0;
    bus.step_btn  = 1'b0;
    bus.clr_count = 1'b0;
    bus.bkpt_en   = 1'b0;
    bus.bkpt_pc   = 8'h00;
    bus.pc_value  = 8'h00;
    track_pc      = 1'b0;
    tick(2);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL reset_halted: got %b expected 1", bus.halted); end
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", bus.instr_count); end
    rst_n = 1'b1;
    tick(5);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", bus.state); end
  endtask

  task automatic test_run();
    logic [1:0] exp_state;
    logic       exp_en;
    do_reset();
    bus.run_sw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      exp_state = (i + 1 >= 3) ? 2'd1 : 2'd0;
      exp_en    = (i + 1 >= 10) && (((i + 1 - 10) % 8) == 0);
      checks++; if (bus.state !== exp_state) begin errors++; $display("FAIL run_state cyc %0d: got %0d expected %0d", i + 1, bus.state, exp_state); end
      checks++; if (bus.cpu_en !== exp_en) begin errors++; $display("FAIL run_cpu_en cyc %0d: got %b expected %b", i + 1, bus.cpu_en, exp_en); end
    end
    checks++; if (bus.instr_count !== 16'd4) begin errors++; $display("FAIL run_count: got %0d expected 4", bus.instr_count); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL run_halted: got %b expected 0", bus.halted); end
  endtask

  task automatic test_step();
    int pulses, at;
    logic [1:0] st_at, st_next;
    do_reset();
    press_btn(1'b1, pulses, at, st_at, st_next);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL step1_pulses: got %0d expected 1", pulses); end
    checks++; if (at !== 10) begin errors++; $display("FAIL step1_time: got %0d expected 10", at); end
    checks++; if (st_at !== 2'd2) begin errors++; $display("FAIL step1_state: got %0d expected 2", st_at); end
    checks++; if (st_next !== 2'd0) begin errors++; $display("FAIL step1_after: got %0d expected 0", st_next); end
    checks++; if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL step1_count: got %0d expected 1", bus.instr_count); end
    press_btn(1'b0, pulses, at, st_at, st_next);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL step2_pulses: got %0d expected 1", pulses); end
    checks++; if (at !== 6) begin errors++; $display("FAIL step2_time: got %0d expected 6", at); end
    checks++; if (bus.instr_count !== 16'd2) begin errors++; $display("FAIL step2_count: got %0d expected 2", bus.instr_count); end
  endtask

  task automatic test_breakpoint();
    int pulses, at, brk_at;
    logic [1:0] st_at, st_next;
    do_reset();
    bus.bkpt_en = 1'b1;
    bus.bkpt_pc = 8'h05;
    track_pc    = 1'b1;
    bus.run_sw  = 1'b1;
    pulses = 0;
    brk_at = -1;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      if (bus.cpu_en) pulses++;
      if (brk_at < 0 && bus.state == 2'd3) brk_at = i;
    end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL bkpt_pulses: got %0d expected 5", pulses); end
    checks++; if (bus.pc_value !== 8'h05) begin errors++; $display("FAIL bkpt_pc: got %0h expected 05", bus.pc_value); end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL bkpt_state: got %0d expected 3", bus.state); end
    checks++; if (brk_at !== 43) begin errors++; $display("FAIL bkpt_time: got %0d expected 43", brk_at); end
    checks++; if (bus.instr_count !== 16'd5) begin errors++; $display("FAIL bkpt_count: got %0d expected 5", bus.instr_count); end
    bus.run_sw = 1'b0;
    tick(3);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL bkpt_exit: got %0d expected 0", bus.state); end
    press_btn(1'b0, pulses, at, st_at, st_next);
    checks++; if (bus.pc_value !== 8'h06) begin errors++; $display("FAIL bkpt_step_pc: got %0h expected 06", bus.pc_value); end
    bus.run_sw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.cpu_en) pulses++;
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL resume_pulses: got %0d expected 2", pulses); end
    checks++; if (bus.pc_value !== 8'h08) begin errors++; $display("FAIL resume_pc: got %0h expected 08", bus.pc_value); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d expected 1", bus.state); end
  endtask

  task automatic test_run_stop();
    int pulses;
    logic [1:0] st6, st7;
    // run_s falls while presc = 7: the last pulse still issues.
    do_reset();
    bus.run_sw = 1'b1;
    tick(8);
    bus.run_sw = 1'b0;
    tick(2);
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL stop7_cpu_en: got %b expected 1", bus.cpu_en); end
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL stop7_state_before: got %0d expected 1", bus.state); end
    tick(1);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL stop7_state: got %0d expected 0", bus.state); end
    checks++; if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL stop7_count: got %0d expected 1", bus.instr_count); end
    // run_s falls while presc = 3: no pulse.
    do_reset();
    bus.run_sw = 1'b1;
    tick(4);
    bus.run_sw = 1'b0;
    pulses = 0;
    st6 = 2'bxx;
    st7 = 2'bxx;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.cpu_en) pulses++;
      if (i == 1) st6 = bus.state;
      if (i == 2) st7 = bus.state;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL stop3_pulses: got %0d expected 0", pulses); end
    checks++; if (st6 !== 2'd1) begin errors++; $display("FAIL stop3_state_before: got %0d expected 1", st6); end
    checks++; if (st7 !== 2'd0) begin errors++; $display("FAIL stop3_state: got %0d expected 0", st7); end
  endtask

  task automatic test_async_reset();
    int pulses, at;
    logic [1:0] st_at, st_next;
    do_reset();
    bus.run_sw = 1'b1;
    tick(18);
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL arst_pre_en: got %b expected 1", bus.cpu_en); end
    checks++; if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL arst_pre_count: got %0d expected 1", bus.instr_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL arst_cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL arst_state: got %0d expected 0", bus.state); end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL arst_halted: got %b expected 1", bus.halted); end
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", bus.instr_count); end
    bus.run_sw = 1'b0;
    #3;
    rst_n = 1'b1;
    press_btn(1'b0, pulses, at, st_at, st_next);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL arst_step_pulses: got %0d expected 1", pulses); end
    checks++; if (at !== 6) begin errors++; $display("FAIL arst_step_time: got %0d expected 6", at); end
    checks++; if (bus.instr_count !== 16'd1) begin errors++; $display("FAIL arst_step_count: got %0d expected 1", bus.instr_count); end
  endtask

  task automatic test_count_sat_clr();
    int pulses, at, total;
    logic [1:0] st_at, st_next;
    do_reset();
    tick(1);
    force dut.instr_cnt_q = 16'hFFFE;
    tick(1);
    release dut.instr_cnt_q;
    tick(1);
    checks++; if (bus.instr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preset: got %0h expected fffe", bus.instr_count); end
    press_btn(1'b0, pulses, at, st_at, st_next);
    total = pulses;
    checks++; if (bus.instr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %0h expected ffff", bus.instr_count); end
    press_btn(1'b0, pulses, at, st_at, st_next);
    total += pulses;
    press_btn(1'b0, pulses, at, st_at, st_next);
    total += pulses;
    checks++; if (total !== 3) begin errors++; $display("FAIL sat_pulses: got %0d expected 3", total); end
    checks++; if (bus.instr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", bus.instr_count); end
    // Clear on the same cycle as an enable: clear wins.
    bus.step_btn = 1'b1;
    tick(7);
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL clr_cpu_en: got %b expected 1", bus.cpu_en); end
    bus.clr_count = 1'b1;
    tick(1);
    bus.clr_count = 1'b0;
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL clr_count: got %0h expected 0", bus.instr_count); end
    tick(5);
    bus.step_btn = 1'b0;
    tick(10);
    checks++; if (bus.instr_count !== 16'd0) begin errors++; $display("FAIL clr_hold: got %0h expected 0", bus.instr_count); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    track_pc = 1'b0;
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_run_stop();
    test_async_reset();
    test_count_sat_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
